// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bus bundle between the instruction fetch unit and its neighbours.
//   imem_*        : instruction-memory read channel (req/addr out, ack/rdata in)
//   instr_*       : issue channel to the decoder (valid/instr/opcode out, ready in)
//   branch, jump, branch_taken, target : redirect information for the
//                   instruction currently being issued
// Modports:
//   master : fetch-unit side
//   slave  : memory / decoder / datapath side
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [5:0]         opcode;

    logic               branch;
    logic               jump;
    logic               branch_taken;
    logic [ADDR_W-1:0]  target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode,
        input  imem_ack, imem_rdata, instr_ready, branch, jump, branch_taken, target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode,
        output imem_ack, imem_rdata, instr_ready, branch, jump, branch_taken, target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetches one instruction word at a time from instruction memory, hands it to
// the decoder with a valid/ready handshake and computes the next program
// counter from the decoded jump/branch information.
//
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : leave IDLE and begin fetching at pc
//   bus      : instr_fetch_unit_if.master (memory read + issue channel)
//   pc       : current program counter (word address)
//   halted   : fetch stopped by a halt (or trapped) opcode; only rst exits
//   trap     : illegal opcode was captured
//
// Build option:
//   IFU_ILLEGAL_TRAP_EN : when defined, opcodes 7..62 halt the unit with
//                         trap=1; when undefined they issue normally and trap
//                         is tied to 0.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    instr_fetch_unit_if.master        bus,
    output logic [ADDR_W-1:0]         pc,
    output logic                      halted,
    output logic                      trap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [5:0] OP_HALT = 6'h3F;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc_p0, pc_nxt;
    logic [INSTR_W-1:0] instr_p1;
    logic               capture;
    logic [5:0]         rdata_op;
    logic               halt_op;
    logic               illegal_op;

    // Jump has priority over a branch; sequential flow wraps naturally.
    function automatic logic [ADDR_W-1:0] next_pc(
        input logic [ADDR_W-1:0] cur,
        input logic              jmp,
        input logic              br,
        input logic              taken,
        input logic [ADDR_W-1:0] tgt
    );
        if (jmp)
            return tgt;
        else if (br && taken)
            return tgt;
        else
            return cur + ADDR_W'(1);
    endfunction

    assign rdata_op = bus.imem_rdata[INSTR_W-1 -: 6];
    assign halt_op  = (rdata_op == OP_HALT);

`ifdef IFU_ILLEGAL_TRAP_EN
    assign illegal_op = (rdata_op >= 6'd7) && (rdata_op <= 6'd62);
`else
    assign illegal_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_p0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = REQ;
            end
            REQ: begin
                if (bus.imem_ack) begin
                    capture = 1'b1;
                    // Halt-class words are captured but never issued; pc keeps
                    // pointing at the word that stopped the fetch.
                    if (halt_op || illegal_op)
                        state_nxt = HALT;
                    else
                        state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    pc_nxt    = next_pc(pc_p0, bus.jump, bus.branch,
                                        bus.branch_taken, bus.target);
                    state_nxt = REQ;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- fetch stage: pc and captured instruction word ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0    <= '0;
            instr_p1 <= '0;
        end else begin
            pc_p0 <= pc_nxt;
            if (capture)
                instr_p1 <= bus.imem_rdata;
        end
    end

`ifdef IFU_ILLEGAL_TRAP_EN
    logic trap_p1;

    always_ff @(posedge clk) begin
        if (rst)
            trap_p1 <= 1'b0;
        else if (capture && illegal_op)
            trap_p1 <= 1'b1;
    end

    assign trap = trap_p1;
`else
    assign trap = 1'b0;
`endif

    // ---- issue stage outputs ----
    assign bus.imem_req    = (state == REQ);
    assign bus.imem_addr   = pc_p0;
    assign bus.instr_valid = (state == ISSUE);
    assign bus.instr       = instr_p1;
    assign bus.opcode      = instr_p1[INSTR_W-1 -: 6];
    assign pc              = pc_p0;
    assign halted          = (state == HALT);

endmodule
